secuenciador_contador: RTL
==========================

Name: secuenciador_contador

Overview:
Command sequencer that sits directly upstream of the 4-bit mode counter and drives its CLK-domain control inputs MODO[1:0], D[3:0] and ENB. Software or test logic pushes commands through a valid/ready handshake into a small FIFO. Each command is (mode, load value, repeat count N). The block replays each command to the counter for N enabled cycles, back-to-back, with a pause input.

Parameters:
DEPTH, 4, command FIFO entries; must be a power of 2, at least 2.
CNT_W, 8, width of the repeat count field.

Ports:
CLK  input  1  system clock; all state updates on the rising edge.
RESET  input  1  asynchronous reset, active-high.
CMD_VALID  input  1  command present on CMD_* this cycle.
CMD_READY  output  1  FIFO can accept a command this cycle.
CMD_MODO  input  2  counter mode for this command (00 up, 01 down, 10 down-by-3, 11 parallel load).
CMD_D  input  4  parallel-load value for this command.
CMD_N  input  CNT_W  number of enabled counter cycles to issue.
HOLD  input  1  pause issuing; sampled every edge.
MODO  output  2  to counter MODO; registered.
D  output  4  to counter D; registered.
ENB  output  1  to counter ENB; registered.
BUSY  output  1  1 while in RUN state.
DONE  output  1  one-cycle pulse marking completion of a command.
FIFO_LVL  output  clog2(DEPTH)+1  number of queued commands, excluding the one executing.

Behaviour:
- Reset (asynchronous, while RESET=1):
  - MODO=00, D=0000, ENB=0, BUSY=0, DONE=0, FIFO_LVL=0, CMD_READY=0.
  - FSM goes to IDLE; FIFO pointers and remaining count clear.
  - Reset asserted mid-command aborts it: no DONE, queued commands lost.
- CMD_READY = (FIFO_LVL != DEPTH) and not in reset. It depends only on registered state, never combinationally on CMD_VALID.
- Push: CMD_VALID & CMD_READY at an edge writes {CMD_MODO, CMD_D, CMD_N} into the FIFO tail. CMD_VALID while CMD_READY=0 is ignored; no drop flag, and the producer must hold the command.
- Push and pop at the same edge: FIFO_LVL is unchanged. When full, CMD_READY=0, so no push occurs even if a pop happens that edge.
- FSM has two states: IDLE and RUN. A register rem[CNT_W-1:0] tracks cycles left.
- IDLE:
  - ENB=0; MODO and D hold their last values.
  - If FIFO non-empty and HOLD=0 at an edge: pop head; MODO<=cmd.MODO, D<=cmd.D.
  - If cmd.N>0: ENB<=1, rem<=N-1, go to RUN; if N=1, DONE<=1 in that same issued cycle.
  - If cmd.N=0: command consumed, ENB stays 0, DONE<=1 for one cycle, stay IDLE.
- RUN (BUSY=1): each cycle with ENB=1 is one issued counter cycle. At each edge:
  - HOLD=1: ENB<=0; rem, MODO and D frozen; DONE<=0.
  - HOLD=0 and rem>0: ENB<=1, rem<=rem-1; DONE<=1 iff rem=1.
  - HOLD=0 and rem=0 (last issued cycle just completed):
    - If FIFO non-empty, pop the next command as in IDLE with no bubble cycle (N=0 entries are consumed and pulse DONE).
    - Otherwise ENB<=0 and go to IDLE.
- DONE is high exactly during the final ENB=1 cycle of a command (or one cycle for N=0). It is never high while ENB=0 in RUN.
- Latency: command pushed at edge k with empty FIFO and IDLE, HOLD=0 → FIFO_LVL=1 in cycle k; popped at edge k+1; ENB=1 in cycles k+1 .. k+N.
- Total ENB=1 cycles per command = N exactly, regardless of HOLD insertion.
- FIFO pointers wrap modulo DEPTH; FIFO_LVL is in the range 0..DEPTH.
- rem never underflows; CMD_N=2^CNT_W-1 is legal.

Test Plan:
1. Reset: RESET=1 mid-run with ENB=1 → immediately MODO=00, D=0, ENB=0, BUSY=0, CMD_READY=0; after release, CMD_READY=1 and FIFO_LVL=0.
2. Single command {01, 0000, N=3} pushed at edge k → ENB=1, MODO=01 in cycles k+1..k+3; DONE=1 only in cycle k+3; BUSY falls after edge k+4.
3. Back-to-back: push {00,-,2} then {11, 1010, 1} → ENB high for 3 consecutive cycles; MODO changes 00→11 with D=1010 on the third with no gap; DONE pulses in cycles 2 and 3.
4. Full FIFO: HOLD=1, push 5 commands with CMD_VALID held → 4 accepted, FIFO_LVL=4, CMD_READY=0; fifth accepted at the edge after HOLD drops and a pop frees a slot.
5. HOLD mid-command: N=4, HOLD=1 for 2 cycles after the 2nd issued cycle → exactly 4 ENB=1 cycles total, MODO/D stable, DONE only on the 4th.
6. Zero count: push {10,-,0} then {00,-,1} → first gives DONE pulse with ENB=0; second gives one ENB=1 cycle with DONE=1.

Source files
------------

// File: rtl/secuenciador_contador.sv
// Command sequencer feeding the 4-bit mode counter (MODO, D, ENB).
// Queues {mode, load value, repeat count} commands and replays each one.
//
// Ports:
//   CLK, RESET            clock, async active-high reset
//   CMD_VALID/CMD_READY   command push handshake
//   CMD_MODO, CMD_D       mode and load value of the pushed command
//   CMD_N                 enabled counter cycles to issue for it
//   HOLD                  pause issuing while high
//   MODO, D, ENB          registered counter controls
//   BUSY                  high while a command is executing
//   DONE                  pulse on the last issued cycle of a command
//   FIFO_LVL              queued commands, not counting the running one
module secuenciador_contador #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic                     CMD_VALID,
   output logic                     CMD_READY,
   input  logic [1:0]               CMD_MODO,
   input  logic [3:0]               CMD_D,
   input  logic [CNT_W-1:0]         CMD_N,
   input  logic                     HOLD,
   output logic [1:0]               MODO,
   output logic [3:0]               D,
   output logic                     ENB,
   output logic                     BUSY,
   output logic                     DONE,
   output logic [$clog2(DEPTH):0]   FIFO_LVL
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   typedef struct packed {
      logic [1:0]       modo;
      logic [3:0]       d;
      logic [CNT_W-1:0] n;
   } cmd_t;

   cmd_t             mem [DEPTH];
   cmd_t             head;
   cmd_t             cmd_in;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [LW-1:0]    lvl;
   logic [CNT_W-1:0] rem;
   state_t           state;
   logic             push;
   logic             pop;
   logic             fifo_ne;
   logic             slot_free;

   assign cmd_in    = '{modo: CMD_MODO, d: CMD_D, n: CMD_N};
   assign head      = mem[rd_ptr];
   assign fifo_ne   = (lvl != '0);
   assign CMD_READY = !RESET && (lvl != LVL_FULL);
   assign push      = CMD_VALID && CMD_READY;

   // The issue slot is free when idle or once the running command has
   // issued its last cycle; popping then gives back-to-back commands.
   assign slot_free = !HOLD && ((state == IDLE) || (rem == '0));
   assign pop       = fifo_ne && slot_free;

   assign BUSY      = (state == RUN);
   assign FIFO_LVL  = lvl;

   always_ff @(posedge CLK) begin
      if (push) begin
         mem[wr_ptr] <= cmd_in;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         lvl    <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         unique case ({push, pop})
            2'b10:   lvl <= lvl + LW'(1);
            2'b01:   lvl <= lvl - LW'(1);
            default: lvl <= lvl;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state <= IDLE;
         rem   <= '0;
         MODO  <= 2'b00;
         D     <= 4'b0000;
         ENB   <= 1'b0;
         DONE  <= 1'b0;
      end else begin
         DONE <= 1'b0;
         if (pop) begin
            MODO <= head.modo;
            D    <= head.d;
            if (head.n != '0) begin
               ENB   <= 1'b1;
               rem   <= head.n - ONE;
               DONE  <= (head.n == ONE);
               state <= RUN;
            end else begin
               // Zero-count command: consumed with a lone DONE pulse.
               ENB   <= 1'b0;
               DONE  <= 1'b1;
               state <= IDLE;
            end
         end else begin
            unique case (state)
               IDLE: begin
                  ENB <= 1'b0;
               end
               RUN: begin
                  if (HOLD) begin
                     ENB <= 1'b0;
                  end else if (rem != '0) begin
                     ENB  <= 1'b1;
                     rem  <= rem - ONE;
                     DONE <= (rem == ONE);
                  end else begin
                     ENB   <= 1'b0;
                     state <= IDLE;
                  end
               end
            endcase
         end
      end
   end

endmodule
